// File: rtl/small_first_one.sv
// rtl/small_first_one.sv - lowest-set-bit finder with combinational and registered outputs
module small_first_one #(
    parameter int WIDTH = 8,
    localparam int INDEX_WIDTH = (WIDTH <= 1) ? 1 : $clog2(WIDTH)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       data,
    output logic [WIDTH-1:0]       first_one,
    output logic [INDEX_WIDTH-1:0] first_one_index,
    output logic                   found,
    output logic [WIDTH-1:0]       first_one_registered,
    output logic [INDEX_WIDTH-1:0] first_one_index_registered,
    output logic                   found_registered
);

    logic [WIDTH-1:0]       first_one_d;
    logic [INDEX_WIDTH-1:0] first_one_index_d;
    logic                   found_d;

    logic [WIDTH-1:0]       first_one_q;
    logic [INDEX_WIDTH-1:0] first_one_index_q;
    logic                   found_q;

    // Isolate the lowest set bit with data & -data, then OR-encode the mask into a binary index.
    always_comb begin
        first_one_d       = data & (~data + WIDTH'(1));
        found_d           = |data;
        first_one_index_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            first_one_index_d = first_one_index_d
                              | (INDEX_WIDTH'(i) & {INDEX_WIDTH{first_one_d[i]}});
        end
    end

    // Sample the combinational results once per clock; reset clears them immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            first_one_q       <= '0;
            first_one_index_q <= '0;
            found_q           <= 1'b0;
        end else begin
            first_one_q       <= first_one_d;
            first_one_index_q <= first_one_index_d;
            found_q           <= found_d;
        end
    end

    assign first_one                  = first_one_d;
    assign first_one_index            = first_one_index_d;
    assign found                      = found_d;
    assign first_one_registered       = first_one_q;
    assign first_one_index_registered = first_one_index_q;
    assign found_registered           = found_q;

endmodule

// File: tb/tb_small_first_one.sv
// tb/tb_small_first_one.sv - self-checking bench for small_first_one
module tb_small_first_one;

    logic       clock;
    logic       reset;
    logic [7:0] data;
    logic [7:0] first_one;
    logic [2:0] first_one_index;
    logic       found;
    logic [7:0] first_one_registered;
    logic [2:0] first_one_index_registered;
    logic       found_registered;

    int errors = 0;
    int checks = 0;

    small_first_one #(.WIDTH(8)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .data                       (data),
        .first_one                  (first_one),
        .first_one_index            (first_one_index),
        .found                      (found),
        .first_one_registered       (first_one_registered),
        .first_one_index_registered (first_one_index_registered),
        .found_registered           (found_registered)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: scan upward from bit 0 and stop at the first one.
    function automatic logic [7:0] ref_mask(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (d[i]) return 8'(1 << i);
        end
        return 8'd0;
    endfunction

    function automatic logic [2:0] ref_index(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (d[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    function automatic logic ref_found(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            if (d[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        data  = 8'b0110_0000;
        #1;
        checks++;
        if ({first_one_registered, first_one_index_registered, found_registered} !== 12'd0) begin
            errors++;
            $display("FAIL reset_regs: got %h/%0d/%b want 0/0/0", first_one_registered,
                     first_one_index_registered, found_registered);
        end
        @(posedge clock); #1;
        checks++;
        if ({first_one_registered, first_one_index_registered, found_registered} !== 12'd0) begin
            errors++;
            $display("FAIL reset_held: got %h/%0d/%b want 0/0/0", first_one_registered,
                     first_one_index_registered, found_registered);
        end
        checks++;
        if (first_one !== 8'b0010_0000 || first_one_index !== 3'd5 || found !== 1'b1) begin
            errors++;
            $display("FAIL reset_comb: got %b/%0d/%b want 00100000/5/1", first_one, first_one_index, found);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (first_one_registered !== 8'b0010_0000 || first_one_index_registered !== 3'd5 ||
            found_registered !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_load: got %b/%0d/%b want 00100000/5/1", first_one_registered,
                     first_one_index_registered, found_registered);
        end
    endtask

    task automatic test_exhaustive();
        for (int v = 0; v < 256; v++) begin
            data = 8'(v);
            #1;
            checks++;
            if (first_one !== ref_mask(data) || first_one_index !== ref_index(data) ||
                found !== ref_found(data)) begin
                errors++;
                $display("FAIL exhaustive d=%b: got %b/%0d/%b want %b/%0d/%b", data, first_one,
                         first_one_index, found, ref_mask(data), ref_index(data), ref_found(data));
            end
        end
    endtask

    task automatic test_directed();
        logic [7:0] vals [4];
        logic [7:0] masks [4];
        logic [2:0] idxs [4];
        logic       fnds [4];
        vals  = '{8'b0000_0000, 8'b1011_0100, 8'b1000_0000, 8'hFF};
        masks = '{8'b0000_0000, 8'b0000_0100, 8'b1000_0000, 8'b0000_0001};
        idxs  = '{3'd0, 3'd2, 3'd7, 3'd0};
        fnds  = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            data = vals[i];
            #1;
            checks++;
            if (first_one !== masks[i] || first_one_index !== idxs[i] || found !== fnds[i]) begin
                errors++;
                $display("FAIL directed d=%b: got %b/%0d/%b want %b/%0d/%b", vals[i], first_one,
                         first_one_index, found, masks[i], idxs[i], fnds[i]);
            end
        end
    endtask

    task automatic test_registered();
        @(negedge clock);
        data = 8'b0110_0000;
        @(posedge clock); #1;
        checks++;
        if (first_one_registered !== 8'b0010_0000 || first_one_index_registered !== 3'd5 ||
            found_registered !== 1'b1) begin
            errors++;
            $display("FAIL registered_path: got %b/%0d/%b want 00100000/5/1", first_one_registered,
                     first_one_index_registered, found_registered);
        end
        @(negedge clock);
        data = 8'h00;
        #1;
        checks++;
        if (first_one_registered !== 8'b0010_0000) begin
            errors++;
            $display("FAIL registered_hold: got %b want 00100000", first_one_registered);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] sent;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            sent = (n % 7 == 0) ? 8'h00 : 8'($urandom);
            data = sent;
            @(posedge clock); #1;
            checks++;
            if (first_one_registered !== ref_mask(sent) ||
                first_one_index_registered !== ref_index(sent) ||
                found_registered !== ref_found(sent)) begin
                errors++;
                $display("FAIL back_to_back d=%b: got %b/%0d/%b want %b/%0d/%b", sent,
                         first_one_registered, first_one_index_registered, found_registered,
                         ref_mask(sent), ref_index(sent), ref_found(sent));
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        data = 8'b0001_1000;
        @(posedge clock); #1;
        checks++;
        if (first_one_registered !== 8'b0000_1000 || found_registered !== 1'b1) begin
            errors++;
            $display("FAIL async_preload: got %b/%b want 00001000/1", first_one_registered, found_registered);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({first_one_registered, first_one_index_registered, found_registered} !== 12'd0) begin
            errors++;
            $display("FAIL async_clear: got %b/%0d/%b want 0/0/0", first_one_registered,
                     first_one_index_registered, found_registered);
        end
        checks++;
        if (first_one !== 8'b0000_1000 || first_one_index !== 3'd3 || found !== 1'b1) begin
            errors++;
            $display("FAIL async_comb_kept: got %b/%0d/%b want 00001000/3/1", first_one, first_one_index, found);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++;
        if (first_one_registered !== 8'd0) begin
            errors++;
            $display("FAIL async_no_early_load: got %b want 0", first_one_registered);
        end
        @(posedge clock); #1;
        checks++;
        if (first_one_registered !== 8'b0000_1000 || first_one_index_registered !== 3'd3 ||
            found_registered !== 1'b1) begin
            errors++;
            $display("FAIL async_reload: got %b/%0d/%b want 00001000/3/1", first_one_registered,
                     first_one_index_registered, found_registered);
        end
    endtask

    initial begin
        reset = 1'b1;
        data  = 8'h00;
        test_reset();
        test_exhaustive();
        test_directed();
        test_registered();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/small_first_one.md
SMALL_FIRST_ONE -- requirements
Module: small_first_one

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data vector width in bits; legal range 1 to 64.
REQ-002 The block SHALL have derived localparam INDEX_WIDTH, default 3 (for WIDTH=8), equal to max(1, clog2(WIDTH)), giving the binary index width.
REQ-003 The block SHALL have port clock, input, 1 bit, the single clock; all registers update on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, an asynchronous active-high reset.
REQ-005 The block SHALL have port data, input, WIDTH bits, the vector to search.
REQ-006 The block SHALL have port first_one, output, WIDTH bits, combinational one-hot mask of the lowest-index set bit of data.
REQ-007 The block SHALL have port first_one_index, output, INDEX_WIDTH bits, combinational binary position of that bit.
REQ-008 The block SHALL have port found, output, 1 bit, combinational flag that data contains at least one set bit.
REQ-009 The block SHALL have port first_one_registered, output, WIDTH bits, first_one sampled on the clock.
REQ-010 The block SHALL have port first_one_index_registered, output, INDEX_WIDTH bits, first_one_index sampled on the clock.
REQ-011 The block SHALL have port found_registered, output, 1 bit, found sampled on the clock.

Function
REQ-012 first_one SHALL be computed as data AND (two's-complement negation of data), the small-area form, with no priority chain or mux tree.
REQ-013 first_one bit i SHALL be 1 only if data[i]=1 and data[j]=0 for every j<i; all other bits SHALL be 0.
REQ-014 When data is all zeros, first_one SHALL be all zeros, first_one_index SHALL be 0 and found SHALL be 0.
REQ-015 first_one SHALL be exactly one-hot whenever found=1.
REQ-016 first_one_index SHALL be the OR-encoding of first_one: bit k is the OR of first_one[i] over all i whose bit k is 1.
REQ-017 found SHALL equal the OR-reduction of data.
REQ-018 first_one, first_one_index and found SHALL be purely combinational, with zero latency from data.
REQ-019 These combinational outputs SHALL NOT depend on clock or reset, and SHALL settle within the same time step as a change on data.
REQ-020 On each rising edge of clock with reset low, each registered output SHALL load its combinational counterpart, giving 1-cycle latency.
REQ-021 For WIDTH=1: first_one SHALL equal data, and first_one_index SHALL be constant 0.
REQ-022 The MSB-only input (data = 1 followed by WIDTH-1 zeros) SHALL produce first_one equal to data and first_one_index equal to WIDTH-1.
REQ-023 The block SHALL contain no other state.

Reset
REQ-024 While reset is high, first_one_registered, first_one_index_registered and found_registered SHALL be 0, asynchronously and without waiting for a clock edge.
REQ-025 On the first rising clock edge after reset deasserts, the registered outputs SHALL load the current combinational values.
REQ-026 Reset asserted mid-operation SHALL clear the registered outputs immediately and SHALL leave the combinational outputs unaffected.

Verification
REQ-027 Exhaustive check, WIDTH=8: apply data 0..255, each held at least 1 ns -> first_one equals the lowest-set-bit mask from a bit-by-bit reference loop, with zero mismatches.
REQ-028 Directed values: data=8'b0000_0000 -> first_one=0, index=0, found=0; data=8'b1011_0100 -> first_one=8'b0000_0100, index=2, found=1.
REQ-029 Boundary values: data=8'b1000_0000 -> first_one=8'b1000_0000, index=7; data=8'hFF -> first_one=8'b0000_0001, index=0.
REQ-030 Registered path: data=8'b0110_0000 applied before an edge -> after 1 clock, first_one_registered=8'b0010_0000, index_registered=5, found_registered=1.
REQ-031 Asynchronous reset: raise reset between clock edges while the registered outputs are nonzero -> they read 0 immediately while the combinational outputs are unchanged; release reset -> they reload on the next edge.
